// File: rtl/button_decoder.sv
// Push-button front end: 2-FF synchroniser, debouncer and gesture FSM that
// turns one raw pin into press/release/short/double/long one-cycle pulses.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | button released, no gesture in progress
// PRESS1    | first press held, timing towards a long press
// LONG_HELD | long press already reported, waiting for release
// WAIT2     | first press released, timing the double-click window
// PRESS2    | second press held, its release reports a double click
module button_decoder #(
  parameter int TANG_NANO_HZ = 24_000_000,
  parameter int DEBOUNCE_MS  = 10,
  parameter int LONG_MS      = 1000,
  parameter int DOUBLE_MS    = 300,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press
);

  localparam int TICKS_PER_MS = TANG_NANO_HZ / 1000;
  localparam int DB_COUNT     = TICKS_PER_MS * DEBOUNCE_MS;
  localparam int LONG_COUNT   = TICKS_PER_MS * LONG_MS;
  localparam int DBL_COUNT    = TICKS_PER_MS * DOUBLE_MS;
  localparam int DB_W         = $clog2(DB_COUNT) + 1;
  localparam int GT_MAX       = (LONG_COUNT > DBL_COUNT) ? LONG_COUNT : DBL_COUNT;
  localparam int GT_W         = $clog2(GT_MAX) + 1;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_COUNT - 1);
  localparam logic [GT_W-1:0] LONG_LAST = GT_W'(LONG_COUNT - 1);
  localparam logic [GT_W-1:0] DBL_LAST  = GT_W'(DBL_COUNT - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRESS1    = 3'd1;
  localparam logic [2:0] ST_LONG_HELD = 3'd2;
  localparam logic [2:0] ST_WAIT2     = 3'd3;
  localparam logic [2:0] ST_PRESS2    = 3'd4;

  logic            sync_q1, sync_q2;
  logic            btn_sync;
  logic [DB_W-1:0] db_cnt;
  logic            level_d;
  logic            press_evt, release_evt;
  logic [2:0]      state;
  logic [GT_W-1:0] timer;
  logic [GT_W-1:0] timer_inc;

  // Flops reset to the released pin level so leaving reset never looks like a press.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_q1 <= ACTIVE_LOW;
      sync_q2 <= ACTIVE_LOW;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign btn_sync = sync_q2 ^ ACTIVE_LOW;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (btn_sync == btn_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt    <= '0;
      btn_level <= ~btn_level;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign press_evt   =  btn_level & ~level_d;
  assign release_evt = ~btn_level &  level_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      level_d       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      level_d       <= btn_level;
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
    end
  end

  assign timer_inc = (&timer) ? timer : timer + GT_W'(1);

  // The FSM reacts to the same edge that launches press/release_pulse, so gesture
  // timing is measured from the cycle those pulses become visible.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      short_click  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
    end else begin
      short_click  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (press_evt) state <= ST_PRESS1;
        end
        ST_PRESS1: begin
          if (release_evt) begin
            state <= ST_WAIT2;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            long_press <= 1'b1;
            state      <= ST_LONG_HELD;
          end else begin
            timer <= timer_inc;
          end
        end
        ST_LONG_HELD: begin
          if (release_evt) state <= ST_IDLE;
        end
        ST_WAIT2: begin
          if (press_evt) begin
            state <= ST_PRESS2;
          end else if (timer == DBL_LAST) begin
            short_click <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            timer <= timer_inc;
          end
        end
        ST_PRESS2: begin
          if (release_evt) begin
            double_click <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_decoder.sv
// Scoreboard bench for button_decoder: stimulus queues expected output events
// with their cycle numbers, an independent monitor pops and checks them.
module tb_button_decoder;

  localparam int K_LUP = 0;
  localparam int K_LDN = 1;
  localparam int K_PR  = 2;
  localparam int K_REL = 3;
  localparam int K_SH  = 4;
  localparam int K_DBL = 5;
  localparam int K_LNG = 6;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic btn_raw = 1'b1;
  logic btn_level, press_pulse, release_pulse, short_click, double_click, long_press;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  ev_t  exp_q[$];

  button_decoder #(
    .TANG_NANO_HZ(1000),
    .DEBOUNCE_MS (4),
    .LONG_MS     (50),
    .DOUBLE_MS   (20),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_click  (short_click),
    .double_click (double_click),
    .long_press   (long_press)
  );

  initial forever #5 sys_clk = ~sys_clk;
  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  function automatic string kname(input int k);
    case (k)
      K_LUP:   return "level_rise";
      K_LDN:   return "level_fall";
      K_PR:    return "press_pulse";
      K_REL:   return "release_pulse";
      K_SH:    return "short_click";
      K_DBL:   return "double_click";
      default: return "long_press";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic seen_ev(input int kind);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got %s at cycle %0d, required none", kname(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        fails++;
        $display("FAIL event_order: got %s at cycle %0d, required %s at cycle %0d",
                 kname(kind), cyc, kname(e.kind), e.cyc);
      end
    end
  endtask

  // Monitor: flags overdue expectations, then checks every visible output event.
  initial begin
    logic prev_level;
    ev_t  e;
    prev_level = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        prev_level = btn_level;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          tests++;
          fails++;
          $display("FAIL missed_event: got nothing by cycle %0d, required %s at cycle %0d",
                   cyc, kname(e.kind), e.cyc);
        end
        if (btn_level != prev_level) seen_ev(btn_level ? K_LUP : K_LDN);
        if (press_pulse)   seen_ev(K_PR);
        if (release_pulse) seen_ev(K_REL);
        if (short_click)   seen_ev(K_SH);
        if (double_click)  seen_ev(K_DBL);
        if (long_press)    seen_ev(K_LNG);
        prev_level = btn_level;
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_btn_level"},     btn_level,     1'b0);
    chk({tag, "_press_pulse"},   press_pulse,   1'b0);
    chk({tag, "_release_pulse"}, release_pulse, 1'b0);
    chk({tag, "_short_click"},   short_click,   1'b0);
    chk({tag, "_double_click"},  double_click,  1'b0);
    chk({tag, "_long_press"},    long_press,    1'b0);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Drive the pin at a falling edge; returns the cycle count at that moment.
  task automatic drive(input logic v, output int t);
    btn_raw = v;
    t = cyc;
  endtask

  initial begin
    int t0, t1;
    // Reset with the pin released, then 100 quiet cycles.
    wait_cyc(3);
    chk_all_zero("reset");
    sys_rst = 1'b0;
    wait_cyc(100);
    chk_all_zero("idle_after_reset");

    // Single click: low 30, high 40.
    drive(1'b0, t0);
    expect_ev(K_LUP, t0 + 6);
    expect_ev(K_PR,  t0 + 7);
    wait_cyc(30);
    drive(1'b1, t1);
    expect_ev(K_LDN, t1 + 6);
    expect_ev(K_REL, t1 + 7);
    expect_ev(K_SH,  t1 + 27);
    wait_cyc(40);

    // 3-cycle glitch must be filtered.
    drive(1'b0, t0);
    wait_cyc(3);
    drive(1'b1, t0);
    wait_cyc(20);
    chk("glitch_level", btn_level, 1'b0);

    // Bounce every 2 cycles for 20 cycles, then settle low -> one press.
    for (int i = 0; i < 10; i++) begin
      drive((i % 2) == 1, t0);
      wait_cyc(2);
    end
    drive(1'b0, t0);
    expect_ev(K_LUP, t0 + 6);
    expect_ev(K_PR,  t0 + 7);
    wait_cyc(15);
    drive(1'b1, t1);
    expect_ev(K_LDN, t1 + 6);
    expect_ev(K_REL, t1 + 7);
    expect_ev(K_SH,  t1 + 27);
    wait_cyc(40);

    // Double click: two 10-cycle presses 10 cycles apart.
    drive(1'b0, t0);
    expect_ev(K_LUP, t0 + 6);
    expect_ev(K_PR,  t0 + 7);
    wait_cyc(10);
    drive(1'b1, t1);
    expect_ev(K_LDN, t0 + 16);
    expect_ev(K_REL, t0 + 17);
    wait_cyc(10);
    drive(1'b0, t1);
    expect_ev(K_LUP, t0 + 26);
    expect_ev(K_PR,  t0 + 27);
    wait_cyc(10);
    drive(1'b1, t1);
    expect_ev(K_LDN, t0 + 36);
    expect_ev(K_REL, t0 + 37);
    expect_ev(K_DBL, t0 + 37);
    wait_cyc(40);

    // Long press: hold 80 cycles.
    drive(1'b0, t0);
    expect_ev(K_LUP, t0 + 6);
    expect_ev(K_PR,  t0 + 7);
    expect_ev(K_LNG, t0 + 57);
    wait_cyc(80);
    drive(1'b1, t1);
    expect_ev(K_LDN, t1 + 6);
    expect_ev(K_REL, t1 + 7);
    wait_cyc(40);

    // Reset 20 cycles into a press, button held through deassert.
    drive(1'b0, t0);
    expect_ev(K_LUP, t0 + 6);
    expect_ev(K_PR,  t0 + 7);
    wait_cyc(20);
    sys_rst = 1'b1;
    #1;
    chk_all_zero("mid_press_reset");
    wait_cyc(3);
    sys_rst = 1'b0;
    t0 = cyc;
    expect_ev(K_LUP, t0 + 6);
    expect_ev(K_PR,  t0 + 7);
    wait_cyc(10);
    drive(1'b1, t1);
    expect_ev(K_LDN, t1 + 6);
    expect_ev(K_REL, t1 + 7);
    expect_ev(K_SH,  t1 + 27);
    wait_cyc(40);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_decoder.md
Name: button_decoder

Overview:
- Input-side counterpart to the board's LED drivers: reads one raw Tang Nano push-button pin and turns it into clean one-cycle user events.
- Pipeline: 2-FF synchroniser -> debouncer -> gesture state machine.
- Events produced: press, release, short click, double click and long press.
- Downstream blocks (LED sequencers, mode selectors) consume the pulses directly in the sys_clk domain.

Parameters:
- TANG_NANO_HZ, 24_000_000, system clock frequency in Hz.
- DEBOUNCE_MS, 10, input must be stable this long before btn_level changes.
- LONG_MS, 1000, hold time that qualifies as a long press.
- DOUBLE_MS, 300, window after a first release in which a second press makes a double click.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (board default); 0 = pin reads 1 when pressed.

Derived (localparam):
- TICKS_PER_MS = TANG_NANO_HZ/1000.
- DB_COUNT = TICKS_PER_MS*DEBOUNCE_MS.
- LONG_COUNT = TICKS_PER_MS*LONG_MS.
- DBL_COUNT = TICKS_PER_MS*DOUBLE_MS.
- Counter widths are $clog2 of the respective max + 1.

Ports:
- sys_clk  input  1  system clock
- sys_rst  input  1  asynchronous, active-high reset
- btn_raw  input  1  raw button pin, asynchronous to sys_clk
- btn_level  output  1  debounced state, 1 = pressed (polarity-normalised)
- press_pulse  output  1  one-cycle pulse when btn_level rises
- release_pulse  output  1  one-cycle pulse when btn_level falls
- short_click  output  1  one-cycle pulse: single press+release, no second press within window
- double_click  output  1  one-cycle pulse: second release of a double click
- long_press  output  1  one-cycle pulse when a first press has been held LONG_COUNT cycles

Behaviour:
- Reset (async assert; deassert sampled on sys_clk):
  - Synchroniser FFs load the released pin level (1 if ACTIVE_LOW, else 0). No spurious press is produced after reset.
  - Debounce counter = 0; btn_level = 0.
  - All pulses = 0; FSM = IDLE; gesture timer = 0.
  - Reset mid-gesture discards the gesture silently.
- Synchroniser:
  - btn_raw passes through 2 flops, then is XORed with ACTIVE_LOW to give sync (1 = pressed).
- Debouncer:
  - If sync == btn_level, counter clears to 0.
  - Otherwise counter increments.
  - When the counter is DB_COUNT-1 and a mismatch is still present, btn_level toggles on that edge and the counter clears.
  - A steady raw change therefore appears on btn_level exactly 2+DB_COUNT cycles later.
  - Any glitch shorter than DB_COUNT cycles never changes btn_level.
- press_pulse / release_pulse: registered edge detect of btn_level, asserted the cycle after btn_level changes.
- Gesture FSM (reacts to press_pulse/release_pulse):
  - IDLE: press -> PRESS1, timer=0.
  - PRESS1: timer++.
    - release before timer reaches LONG_COUNT-1 -> WAIT2, timer=0.
    - timer == LONG_COUNT-1 while held -> long_press=1, go to LONG_HELD.
  - LONG_HELD: release -> IDLE. No click is generated.
  - WAIT2: timer++.
    - press while timer < DBL_COUNT-1 -> PRESS2.
    - timer == DBL_COUNT-1 -> short_click=1, go to IDLE.
    - If press and timeout occur in the same cycle, the press wins: PRESS2, no short_click.
  - PRESS2: no long detection. release -> double_click=1, go to IDLE.
- Timers saturate; there is no wrap-around.
- At most one gesture pulse (short/double/long) is asserted in any cycle.
- All outputs are registered.

Test Plan (TANG_NANO_HZ=1000, DEBOUNCE_MS=4, LONG_MS=50, DOUBLE_MS=20, ACTIVE_LOW=1; DB=4, LONG=50, DBL=20 cycles):
- Reset with btn_raw=1, then release reset -> all outputs stay 0 for 100 cycles.
- btn_raw low 30 cycles, then high 40 cycles:
  - btn_level rises exactly 6 cycles after the falling edge.
  - press_pulse follows 1 cycle later; release_pulse likewise after the rise.
  - short_click fires once, DBL_COUNT cycles after the release pulse.
  - No double_click or long_press.
- Glitch: btn_raw low 3 cycles, then high -> btn_level never rises, no pulses. Bouncing low/high every 2 cycles for 20 cycles, then low -> a single press_pulse.
- Two 10-cycle presses separated by 10 cycles high -> exactly one double_click, on the second release; no short_click.
- Hold low 80 cycles -> long_press exactly once, 50 cycles after press_pulse. Release -> release_pulse only, no click.
- Assert sys_rst mid-PRESS1 (20 cycles into a press), then hold the button through deassert:
  - All outputs 0 immediately.
  - After deassert, btn_level re-rises 6 cycles later and a fresh gesture starts.
